// File: rtl/pht_write_scheduler_if.sv
// Handshake and table-write bundle between decode/fetch and the PHT
// write scheduler.
interface pht_write_scheduler_if #(
    parameter int IWIDTH = 6,
    parameter int CWIDTH = 2
);
    logic              upd_valid;
    logic [IWIDTH-1:0] upd_index;
    logic [CWIDTH-1:0] upd_cnt;
    logic              upd_ready;

    logic              alloc_valid;
    logic [IWIDTH-1:0] alloc_index;
    logic [CWIDTH-1:0] alloc_cnt;
    logic              alloc_drop;

    logic              flush_req;
    logic              flush_done;
    logic              busy;

    logic              tbl_we;
    logic [IWIDTH-1:0] tbl_index;
    logic              tbl_valid;
    logic [CWIDTH-1:0] tbl_cnt;

    modport master (
        output upd_valid, upd_index, upd_cnt,
        output alloc_valid, alloc_index, alloc_cnt,
        output flush_req,
        input  upd_ready, alloc_drop, flush_done, busy,
        input  tbl_we, tbl_index, tbl_valid, tbl_cnt
    );

    modport slave (
        input  upd_valid, upd_index, upd_cnt,
        input  alloc_valid, alloc_index, alloc_cnt,
        input  flush_req,
        output upd_ready, alloc_drop, flush_done, busy,
        output tbl_we, tbl_index, tbl_valid, tbl_cnt
    );
endinterface

// File: rtl/pht_write_scheduler.sv
// Arbitrates the single PHT write port between buffered branch updates,
// fetch-miss allocations and a whole-table invalidation sweep.
module pht_write_scheduler #(
    parameter int IWIDTH = 6,
    parameter int CWIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pht_write_scheduler_if.slave bus
);
    localparam int N = 2 ** IWIDTH;
    localparam logic [IWIDTH:0] LAST = (IWIDTH + 1)'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IWIDTH:0] sweep_cnt;
    logic [IWIDTH:0] sweep_nxt;

    logic [IWIDTH-1:0] fifo_index [2];
    logic [CWIDTH-1:0] fifo_cnt   [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              idle;
    logic              empty;
    logic              push;
    logic              pop;
    logic              flush_go;
    logic              we;
    logic [IWIDTH-1:0] index;
    logic              valid;
    logic [CWIDTH-1:0] cnt;
    logic              done;

    always_comb begin
        idle     = (state == IDLE);
        empty    = (count == 2'd0);
        flush_go = idle && bus.flush_req;
        push     = bus.upd_valid && bus.upd_ready;
        pop      = idle && !bus.flush_req && !empty;
    end

    assign bus.upd_ready  = idle && (count < 2'd2) && !bus.flush_req;
    assign bus.alloc_drop = bus.alloc_valid
                          && !(idle && empty && !bus.flush_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_cnt;
        we        = 1'b0;
        index     = '0;
        valid     = 1'b0;
        cnt       = '0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush_req) begin
                    state_nxt = SWEEP;
                    sweep_nxt = '0;
                end else if (!empty) begin
                    we    = 1'b1;
                    index = fifo_index[rd_ptr];
                    valid = 1'b1;
                    cnt   = fifo_cnt[rd_ptr];
                end else if (bus.alloc_valid) begin
                    we    = 1'b1;
                    index = bus.alloc_index;
                    valid = 1'b1;
                    cnt   = bus.alloc_cnt;
                end
            end
            SWEEP: begin
                we        = 1'b1;
                index     = sweep_cnt[IWIDTH-1:0];
                sweep_nxt = sweep_cnt + 1'b1;
                // Wider counter compared against N-1 so the exit never aliases.
                if (sweep_cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Suppress writes while reset is held: the table must not see a stray alloc.
    assign bus.tbl_we     = we && !reset;
    assign bus.tbl_index  = index;
    assign bus.tbl_valid  = valid;
    assign bus.tbl_cnt    = cnt;
    assign bus.flush_done = done;
    assign bus.busy       = !idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush_go) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_index[wr_ptr] <= bus.upd_index;
            fifo_cnt[wr_ptr]   <= bus.upd_cnt;
        end
    end
endmodule

// File: tb/tb_pht_write_scheduler.sv
// Bench for pht_write_scheduler: directed vectors, flush/reset corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pht_write_scheduler;
    localparam int IW  = 4;
    localparam int CW  = 2;
    localparam int N   = 16;
    localparam int IW3 = 3;
    localparam int N3  = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pht_write_scheduler_if #(.IWIDTH(IW),  .CWIDTH(CW)) bus ();
    pht_write_scheduler_if #(.IWIDTH(IW3), .CWIDTH(CW)) bus3 ();

    pht_write_scheduler #(.IWIDTH(IW), .CWIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pht_write_scheduler #(.IWIDTH(IW3), .CWIDTH(CW)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic          uv;
        logic [IW-1:0] ui;
        logic [CW-1:0] uc;
        logic          av;
        logic [IW-1:0] ai;
        logic [CW-1:0] ac;
        logic          fl;
        logic          we;
        logic [IW-1:0] ti;
        logic          tv;
        logic [CW-1:0] tc;
        logic          rdy;
        logic          drp;
        logic          bsy;
        logic          dn;
    } vec_t;

    function automatic vec_t mk(
        input logic uv, input int ui, input int uc,
        input logic av, input int ai, input int ac, input logic fl,
        input logic we, input int ti, input logic tv, input int tc,
        input logic rdy, input logic drp, input logic bsy, input logic dn);
        vec_t v;
        v.uv = uv; v.ui = IW'(ui); v.uc = CW'(uc);
        v.av = av; v.ai = IW'(ai); v.ac = CW'(ac); v.fl = fl;
        v.we = we; v.ti = IW'(ti); v.tv = tv; v.tc = CW'(tc);
        v.rdy = rdy; v.drp = drp; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    typedef struct {
        logic [IW-1:0] i;
        logic [CW-1:0] c;
    } ent_t;

    vec_t vt[14];
    ent_t q[$];
    int   sweep_pos;

    task automatic drive_idle();
        bus.upd_valid   = 1'b0; bus.upd_index   = '0; bus.upd_cnt   = '0;
        bus.alloc_valid = 1'b0; bus.alloc_index = '0; bus.alloc_cnt = '0;
        bus.flush_req   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        // uv ui uc | av ai ac | fl || we ti tv tc | rdy drp bsy dn
        vt[0]  = mk(1,5,3, 0,0,0, 0,  0,0,0,0, 1,0,0,0);
        vt[1]  = mk(0,0,0, 0,0,0, 0,  1,5,1,3, 1,0,0,0);
        vt[2]  = mk(0,0,0, 0,0,0, 0,  0,0,0,0, 1,0,0,0);
        vt[3]  = mk(1,1,1, 0,0,0, 0,  0,0,0,0, 1,0,0,0);
        vt[4]  = mk(1,2,2, 0,0,0, 0,  1,1,1,1, 1,0,0,0);
        vt[5]  = mk(1,3,3, 0,0,0, 0,  1,2,1,2, 1,0,0,0);
        vt[6]  = mk(0,0,0, 0,0,0, 0,  1,3,1,3, 1,0,0,0);
        vt[7]  = mk(0,0,0, 0,0,0, 0,  0,0,0,0, 1,0,0,0);
        vt[8]  = mk(1,4,0, 1,9,2, 0,  1,9,1,2, 1,0,0,0);
        vt[9]  = mk(0,0,0, 1,9,1, 0,  1,4,1,0, 1,1,0,0);
        vt[10] = mk(0,0,0, 1,9,1, 0,  1,9,1,1, 1,0,0,0);
        vt[11] = mk(1,7,1, 1,7,2, 0,  1,7,1,2, 1,0,0,0);
        vt[12] = mk(0,0,0, 1,7,3, 0,  1,7,1,1, 1,1,0,0);
        vt[13] = mk(1,8,1, 1,1,1, 1,  0,0,0,0, 0,1,0,0);

        drive_idle();
        bus3.upd_valid   = 1'b0; bus3.upd_index   = '0; bus3.upd_cnt = '0;
        bus3.alloc_valid = 1'b0; bus3.alloc_index = '0; bus3.alloc_cnt = '0;
        bus3.flush_req   = 1'b0;
        reset = 1'b1;

        // Reset-state outputs, with an alloc offered while reset is held.
        bus.alloc_valid = 1'b1;
        bus.alloc_index = 4'd3;
        @(negedge clk);
        chk("rst_we", 32'(bus.tbl_we), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.flush_done), 0);
        chk("rst_ready", 32'(bus.upd_ready), 1);
        chk("rst_drop", 32'(bus.alloc_drop), 0);
        bus.flush_req = 1'b1;
        #1;
        chk("rst_ready_flush", 32'(bus.upd_ready), 0);
        next_cycle();
        drive_idle();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            bus.upd_valid   = vt[i].uv;
            bus.upd_index   = vt[i].ui;
            bus.upd_cnt     = vt[i].uc;
            bus.alloc_valid = vt[i].av;
            bus.alloc_index = vt[i].ai;
            bus.alloc_cnt   = vt[i].ac;
            bus.flush_req   = vt[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), 32'(bus.tbl_we), 32'(vt[i].we));
            if (vt[i].we) begin
                chk($sformatf("vec%0d_idx", i), 32'(bus.tbl_index),
                    32'(vt[i].ti));
                chk($sformatf("vec%0d_val", i), 32'(bus.tbl_valid),
                    32'(vt[i].tv));
                chk($sformatf("vec%0d_cnt", i), 32'(bus.tbl_cnt),
                    32'(vt[i].tc));
            end
            chk($sformatf("vec%0d_rdy", i), 32'(bus.upd_ready),
                32'(vt[i].rdy));
            chk($sformatf("vec%0d_drop", i), 32'(bus.alloc_drop),
                32'(vt[i].drp));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].bsy));
            chk($sformatf("vec%0d_done", i), 32'(bus.flush_done),
                32'(vt[i].dn));
            next_cycle();
        end
        drive_idle();

        // The last vector started a sweep: walk to index 4, then reset.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sw_we", 32'(bus.tbl_we), 1);
            chk("sw_idx", 32'(bus.tbl_index), 32'(k));
            chk("sw_val", 32'(bus.tbl_valid), 0);
            chk("sw_busy", 32'(bus.busy), 1);
            next_cycle();
        end
        chk("sw_idx4", 32'(bus.tbl_index), 4);
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(bus.tbl_we), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(bus.flush_done), 0);
            chk("abort_idle", 32'(bus.busy), 0);
            next_cycle();
        end

        // Depth-8 flush with one buffered update; flush held through sweep.
        bus3.upd_valid = 1'b1;
        bus3.upd_index = 3'd2;
        bus3.upd_cnt   = 2'd1;
        @(negedge clk);
        chk("f8_push_rdy", 32'(bus3.upd_ready), 1);
        chk("f8_push_we", 32'(bus3.tbl_we), 0);
        next_cycle();
        bus3.upd_valid = 1'b0;
        bus3.flush_req = 1'b1;
        @(negedge clk);
        chk("f8_req_we", 32'(bus3.tbl_we), 0);
        chk("f8_req_rdy", 32'(bus3.upd_ready), 0);
        chk("f8_req_busy", 32'(bus3.busy), 0);
        next_cycle();
        for (int k = 0; k < N3; k++) begin
            @(negedge clk);
            chk("f8_we", 32'(bus3.tbl_we), 1);
            chk("f8_idx", 32'(bus3.tbl_index), 32'(k));
            chk("f8_val", 32'(bus3.tbl_valid), 0);
            chk("f8_cnt", 32'(bus3.tbl_cnt), 0);
            chk("f8_busy", 32'(bus3.busy), 1);
            chk("f8_rdy", 32'(bus3.upd_ready), 0);
            chk("f8_done", 32'(bus3.flush_done), 0);
            next_cycle();
        end
        @(negedge clk);
        chk("f8_pulse", 32'(bus3.flush_done), 1);
        chk("f8_pulse_we", 32'(bus3.tbl_we), 0);
        chk("f8_pulse_busy", 32'(bus3.busy), 1);
        chk("f8_pulse_rdy", 32'(bus3.upd_ready), 0);
        next_cycle();
        bus3.flush_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("f8_after_we", 32'(bus3.tbl_we), 0);
            chk("f8_after_busy", 32'(bus3.busy), 0);
            chk("f8_after_done", 32'(bus3.flush_done), 0);
            chk("f8_after_rdy", 32'(bus3.upd_ready), 1);
            next_cycle();
        end

        // Randomized traffic against the queue model.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        q.delete();
        sweep_pos = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic idle;
            logic e_we, e_val, e_rdy, e_drp;
            logic [IW-1:0] e_idx;
            logic [CW-1:0] e_cnt;

            reset           = ($urandom_range(0, 149) == 0);
            bus.upd_valid   = 1'($urandom);
            bus.upd_index   = IW'($urandom);
            bus.upd_cnt     = CW'($urandom);
            bus.alloc_valid = 1'($urandom);
            bus.alloc_index = IW'($urandom);
            bus.alloc_cnt   = CW'($urandom);
            bus.flush_req   = ($urandom_range(0, 29) == 0);
            @(negedge clk);

            if (reset) begin
                q.delete();
                sweep_pos = -1;
            end
            idle  = (sweep_pos < 0);
            e_rdy = idle && (q.size() < 2) && !bus.flush_req;
            e_drp = bus.alloc_valid
                  && !(idle && q.size() == 0 && !bus.flush_req);
            e_we  = 1'b0; e_idx = '0; e_val = 1'b0; e_cnt = '0;
            if (idle && !bus.flush_req && q.size() > 0) begin
                e_we = 1'b1; e_idx = q[0].i; e_val = 1'b1; e_cnt = q[0].c;
            end else if (idle && !bus.flush_req && bus.alloc_valid) begin
                e_we = 1'b1; e_idx = bus.alloc_index; e_val = 1'b1;
                e_cnt = bus.alloc_cnt;
            end else if (sweep_pos >= 0 && sweep_pos < N) begin
                e_we = 1'b1; e_idx = IW'(sweep_pos);
            end
            if (reset) e_we = 1'b0;

            chk("rnd_we", 32'(bus.tbl_we), 32'(e_we));
            if (e_we) begin
                chk("rnd_idx", 32'(bus.tbl_index), 32'(e_idx));
                chk("rnd_val", 32'(bus.tbl_valid), 32'(e_val));
                chk("rnd_cnt", 32'(bus.tbl_cnt), 32'(e_cnt));
            end
            chk("rnd_rdy", 32'(bus.upd_ready), 32'(e_rdy));
            chk("rnd_drop", 32'(bus.alloc_drop), 32'(e_drp));
            chk("rnd_busy", 32'(bus.busy), 32'(!idle));
            chk("rnd_done", 32'(bus.flush_done), 32'(sweep_pos == N));

            if (!reset) begin
                if (idle && bus.flush_req) begin
                    q.delete();
                    sweep_pos = 0;
                end else if (idle) begin
                    if (q.size() > 0) void'(q.pop_front());
                    if (bus.upd_valid && e_rdy)
                        q.push_back('{i: bus.upd_index, c: bus.upd_cnt});
                end else if (sweep_pos == N) begin
                    sweep_pos = -1;
                end else begin
                    sweep_pos++;
                end
            end
            next_cycle();
        end

        reset = 1'b0;
        drive_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pht_write_scheduler.md
PHT_WRITE_SCHEDULER -- requirements
Module: pht_write_scheduler

Interface
REQ-001 SHALL have parameter IWIDTH, default 6, table index width; table depth N = 2**IWIDTH.
REQ-002 SHALL have parameter CWIDTH, default 2, saturating-counter width.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port upd_valid  in  1  decode presents a resolved-branch counter write.
REQ-006 SHALL have port upd_index  in  IWIDTH  table entry of the update.
REQ-007 SHALL have port upd_cnt  in  CWIDTH  new counter value (already saturated upstream).
REQ-008 SHALL have port upd_ready  out  1  update accepted this cycle when upd_valid && upd_ready.
REQ-009 SHALL have port alloc_valid  in  1  fetch-miss allocation hint.
REQ-010 SHALL have port alloc_index  in  IWIDTH  entry to allocate.
REQ-011 SHALL have port alloc_cnt  in  CWIDTH  initial counter for the allocation.
REQ-012 SHALL have port alloc_drop  out  1  allocation offered this cycle and not written.
REQ-013 SHALL have port flush_req  in  1  request to invalidate the whole table.
REQ-014 SHALL have port flush_done  out  1  one-cycle pulse when the sweep has finished.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have ports tbl_we (1), tbl_index (IWIDTH), tbl_valid (1), tbl_cnt (CWIDTH)  out  single table write port.

Function
REQ-017 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-018 IDLE: flush_req=1 SHALL move to SWEEP, clear sweep counter to 0, discard all update-FIFO entries.
REQ-019 SWEEP: each cycle SHALL drive tbl_we=1, tbl_index=sweep counter, tbl_valid=0, tbl_cnt=0; counter +1 per cycle.
REQ-020 SWEEP SHALL last exactly N cycles (indices 0..N-1); after index N-1 SHALL enter DONE; counter SHALL be IWIDTH+1 bits or compare N-1 so no wrap aliasing.
REQ-021 DONE SHALL last one cycle with flush_done=1, tbl_we=0, then return to IDLE.
REQ-022 flush_req in SWEEP or DONE SHALL be ignored; flush_req in IDLE same cycle as upd/alloc: flush wins, that cycle's update not accepted (upd_ready=0), alloc dropped.
REQ-023 Updates SHALL enter a 2-entry FIFO of {index, cnt}; upd_ready = (state==IDLE) && (count<2) && !flush_req, combinational.
REQ-024 Accepted update SHALL be written no earlier than the cycle after acceptance (no bypass).
REQ-025 IDLE write priority: FIFO head first (tbl_valid=1, head index/cnt, pop), else alloc (tbl_valid=1, alloc_index/cnt).
REQ-026 alloc_drop SHALL equal alloc_valid && !(state==IDLE && FIFO empty && !flush_req).
REQ-027 Simultaneous push and pop SHALL be legal when count is 1; count unchanged; order preserved FIFO.
REQ-028 Push when full SHALL not occur since upd_ready=0; FIFO SHALL never overflow or reorder.
REQ-029 Same index from FIFO head and alloc in one cycle: FIFO write only, alloc dropped.
REQ-030 tbl_we SHALL be 0 when no source is granted; tbl_index/tbl_cnt/tbl_valid don't-care then.
REQ-031 busy SHALL be 1 in SWEEP and DONE, 0 in IDLE.

Reset
REQ-032 reset SHALL asynchronously force IDLE, FIFO count 0, sweep counter 0.
REQ-033 Outputs during/after reset: tbl_we=0, flush_done=0, busy=0, alloc_drop follows REQ-026, upd_ready=!flush_req.
REQ-034 reset mid-SWEEP SHALL abort the sweep with no flush_done; no resumption after release.

Verification
REQ-035 Reset, then upd (idx 5, cnt 3) accepted cycle 0 -> cycle 1 tbl_we=1, index 5, valid 1, cnt 3; cycle 2 tbl_we=0.
REQ-036 Updates idx 1,2,3 offered on back-to-back cycles, no alloc -> all accepted (idx 3 with simultaneous pop at count 1), writes 1,2,3 in order cycles 1-3.
REQ-037 FIFO holds 2 entries and alloc_valid idx 9 -> alloc_drop=1, FIFO head written; alloc idx 9 with FIFO empty -> written, alloc_drop=0.
REQ-038 IWIDTH=3, flush_req in IDLE with 1 FIFO entry -> 8 write cycles idx 0..7 valid 0 cnt 0, FIFO discarded, flush_done pulse on 9th cycle, busy high 9 cycles, upd_ready 0 throughout.
REQ-039 flush_req re-asserted during SWEEP -> sweep length unchanged, single flush_done.
REQ-040 reset asserted at sweep index 4 -> tbl_we=0 immediately, busy=0, no flush_done after release.
